// File: rtl/custom_inputs.sv
// custom_inputs: Avalon-MM slave that exposes buttons and DIP switches to the HPS.
// Each pin is synchronized, polarity-normalized and debounced. Rising edges are
// latched into a write-1-to-clear capture register that drives a maskable level
// interrupt, and a 16-bit counter tallies every accepted rising edge.
module custom_inputs #(
    parameter int unsigned      WIDTH           = 8,
    parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = 8'h0F,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_s0_address,
    input  logic             avs_s0_read,
    output logic [31:0]      avs_s0_readdata,
    input  logic             avs_s0_write,
    input  logic [31:0]      avs_s0_writedata,
    input  logic [WIDTH-1:0] inputs_new_signal,
    output logic             irq
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned     COUNT_W = 16;
    localparam int unsigned     DATA_W  = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    // Input path state
    logic [WIDTH-1:0]   sync1_q;
    logic [WIDTH-1:0]   sync2_q;
    logic [WIDTH-1:0]   norm;
    logic [WIDTH-1:0]   deb_q;
    logic [WIDTH-1:0]   deb_d;
    logic [CNT_W-1:0]   cnt_q [WIDTH];
    logic [CNT_W-1:0]   cnt_d [WIDTH];
    logic [WIDTH-1:0]   rise;

    // Register file state
    logic [WIDTH-1:0]   irqmask_q;
    logic [WIDTH-1:0]   edge_q;
    logic [WIDTH-1:0]   edge_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] rise_count;
    logic [DATA_W-1:0]  rd_mux;

    // Bus decode
    logic               wr_irqmask;
    logic               wr_edge;
    logic               wr_count;
    logic [WIDTH-1:0]   wdata_bits;
    logic [DATA_W-1:0]  wdata_unused;

    assign wr_irqmask   = avs_s0_write && (avs_s0_address == ADDR_IRQMASK);
    assign wr_edge      = avs_s0_write && (avs_s0_address == ADDR_EDGE);
    assign wr_count     = avs_s0_write && (avs_s0_address == ADDR_COUNT);
    assign wdata_bits   = avs_s0_writedata[WIDTH-1:0];
    assign wdata_unused = avs_s0_writedata;

    // Active-low pins are flipped so that 1 always means "pressed / on"
    assign norm = sync2_q ^ ACTIVE_LOW_MASK;

    // Two-flop synchronizer, reset to the inactive pin level so norm starts at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
        end else begin
            sync1_q <= inputs_new_signal;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: accept a change only after DEBOUNCE_CYCLES mismatching cycles
    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        cnt_d = '{default: '0};
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (norm[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = norm[i];
                    rise[i]  = norm[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state; a reset abandons any in-flight debounce
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Number of bits rising this cycle, used to advance COUNT
    always_comb begin
        rise_count = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            rise_count = rise_count + COUNT_W'(rise[i]);
        end
    end

    // Capture and counter next state: a new rise beats a same-cycle clear
    always_comb begin
        edge_d  = (edge_q & ~(wr_edge ? wdata_bits : '0)) | rise;
        count_d = (wr_count ? '0 : count_q) + rise_count;
    end

    // Register file update
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            edge_q    <= '0;
            count_q   <= '0;
        end else begin
            if (wr_irqmask) begin
                irqmask_q <= wdata_bits;
            end
            edge_q  <= edge_d;
            count_q <= count_d;
        end
    end

    // Read mux from pre-update register state, so a same-cycle write reads old data
    always_comb begin
        rd_mux = '0;
        case (avs_s0_address)
            ADDR_DATA:    rd_mux = DATA_W'(deb_q);
            ADDR_IRQMASK: rd_mux = DATA_W'(irqmask_q);
            ADDR_EDGE:    rd_mux = DATA_W'(edge_q);
            ADDR_COUNT:   rd_mux = DATA_W'(count_q);
            default:      rd_mux = '0;
        endcase
    end

    // Read data register: latency 1, holds its value between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_s0_readdata <= '0;
        end else if (avs_s0_read) begin
            avs_s0_readdata <= rd_mux;
        end
    end

    // Level interrupt straight from registered capture and mask state
    assign irq = |(edge_q & irqmask_q);

endmodule

// File: doc/custom_inputs.md
# custom_inputs

Avalon-MM slave that brings board push-buttons and DIP switches into the HPS address space. It is the input-side companion to the `custom_leds` output peripheral and sits on the lightweight HPS-to-FPGA bridge. Each input is synchronized, debounced, and polarity-normalized. Rising edges are latched into a write-1-to-clear capture register that drives a maskable level interrupt, and a 16-bit event counter tallies them.

## Interface
- `WIDTH`, default 8: number of input bits. Bits [3:0] are buttons; bits [7:4] are switches.
- `ACTIVE_LOW_MASK`, default 8'h0F: a 1 marks an input that is active-low, and it is inverted after synchronization.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a change (1 ms at 50 MHz). Must be ≥ 2.
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high reset.
- `avs_s0_address`  in  2: register select.
- `avs_s0_read`  in  1: read strobe.
- `avs_s0_readdata`  out  32: read data, fixed read latency 1.
- `avs_s0_write`  in  1: write strobe.
- `avs_s0_writedata`  out-of-band  in  32: write data.
- `inputs_new_signal`  in  WIDTH: raw asynchronous pins.
- `irq`  out  1: level interrupt, active-high.

## Operation
- Input path, per bit:
  - 2-FF synchronizer.
  - XOR with `ACTIVE_LOW_MASK` gives the normalized value `n`.
  - Debounce counter `cnt` of width clog2(`DEBOUNCE_CYCLES`).
  - Debounced register `deb`.
- Debounce rule, per bit, every cycle:
  - If `n == deb`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= n`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` leaves `deb` unchanged.
- `rise[i]` = the update cycle in which `deb[i]` goes 0→1. Falling edges are not captured.
- Register map (word addresses):
  - 0 DATA: read-only, `deb` zero-extended. Writes are ignored.
  - 1 IRQMASK: R/W, bits [WIDTH-1:0]. Upper bits read 0.
  - 2 EDGE: read returns the capture bits. Write 1 to clear: `edge <= (edge & ~wdata) | rise`. A set wins over a same-cycle clear.
  - 3 COUNT: read-only value of the 16-bit counter. Each cycle it adds popcount(`rise`), modulo 2^16, so 0xFFFF+1 = 0x0000. Any write sets it to 0; rises in that same cycle are then added to 0.
- `irq = |(edge & irqmask)`, combinational from registers only.

## Timing
- Reset values:
  - `avs_s0_readdata` = 0, `irq` = 0.
  - Synchronizer flops are loaded with the inactive level, so `n` = 0.
  - `deb`, `cnt`, `edge`, `irqmask`, and COUNT are all 0.
- Reset mid-operation abandons any debounce in progress. An input still active after reset release is treated as a new press: `deb` rises, and `edge` and COUNT update.
- Pin-to-`deb` latency: 2 synchronizer cycles + `DEBOUNCE_CYCLES`.
  - `edge`, COUNT, and `irq` change on the same clock edge as `deb`.
- Read: `avs_s0_read` sampled at edge k returns data at edge k+1.
  - The value is taken from register state before edge k's updates.
  - `readdata` holds its last value when no read occurs.
- Write: takes effect at the sampling edge and is visible to a read issued on the next cycle. No wait-request; every access completes in one cycle.
- A simultaneous read and write to the same address returns the old value.
- Bits at or above WIDTH: ignored on write, read back as 0.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4.

1. Reset, then read all four addresses → each returns 0x0; `irq`=0.
2. Press `inputs_new_signal[0]` (drive it 0) and hold → after 6 cycles DATA reads 0x01, EDGE reads 0x01, COUNT reads 1. `irq` stays 0 because IRQMASK = 0.
3. Write IRQMASK=0x01 with EDGE[0] set → `irq`=1 on the next cycle. Write EDGE=0x01 → `irq`=0 one cycle later, and EDGE reads 0.
4. Drive 3-cycle pulses on `inputs_new_signal[5]` (active-high) → DATA, EDGE, and COUNT are unchanged. A 4-cycle stable high then sets DATA[5] and EDGE[5].
5. Preload COUNT to 0xFFFF via 65535 rises, or force it in the bench, then one rise → COUNT reads 0x0000. Writing COUNT in the same cycle as a rise → COUNT reads 1.
6. Clear EDGE[1] in the same cycle that `rise[1]` fires → EDGE[1] remains 1. Hold a button active through a reset pulse → after release, EDGE sets again after 6 cycles.
